reaction_ctrl: RTL



---
 rtl/reaction_pkg.sv | 28 ++
 rtl/ms_tick_gen.sv | 29 ++
 rtl/reaction_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared types and helpers for the reaction-timer controller.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    DELAY,
    GO,
    DONE,
    FAULT
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned first_set(input logic [7:0] v);
    logic found;
    first_set = 0;
    found     = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i] && !found) begin
        first_set = i;
        found     = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick prescaler: one-cycle tick every TICK_DIV clocks, restartable via clr.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign tick   = w_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Multi-player reaction-timer controller: random delay, go window with timeout,
// false-start detection and lowest-index first-press arbitration.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned TIME_W         = 11,
  parameter int unsigned DELAY_MIN_MS   = 1000,
  parameter int unsigned DELAY_RANGE_MS = 1024,
  parameter int unsigned TIMEOUT_MS     = 2000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  localparam int unsigned WIN_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_PLAYERS-1:0] btn,
  output logic                   go,
  output logic                   capture,
  output logic [TIME_W-1:0]      result_ms,
  output logic [WIN_W-1:0]       winner,
  output logic                   false_start,
  output logic                   timeout,
  output logic                   busy
);

  localparam int unsigned DLY_W     = 17;
  localparam logic [15:0] LFSR_MASK = 16'(DELAY_RANGE_MS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_lfsr;
  logic [DLY_W-1:0]  r_delay;
  logic [DLY_W-1:0]  w_delay_load;
  logic [TIME_W-1:0] r_rt;
  logic              w_tick;
  logic              w_tick_clr;
  logic              w_any;
  logic [WIN_W-1:0]  w_first;

  logic              w_cap;
  logic [TIME_W-1:0] w_cap_res;
  logic [WIN_W-1:0]  w_cap_win;
  logic              w_cap_fs;
  logic              w_cap_to;

  logic              r_go;
  logic              r_capture;
  logic [TIME_W-1:0] r_result;
  logic [WIN_W-1:0]  r_winner;
  logic              r_false_start;
  logic              r_timeout;
  logic              r_busy;

  assign w_any        = |btn;
  assign w_first      = WIN_W'(first_set(8'(btn)));
  assign w_delay_load = DLY_W'(DELAY_MIN_MS) + DLY_W'(r_lfsr & LFSR_MASK);
  assign w_tick_clr   = ((w_state_nxt == DELAY) && (r_state != DELAY)) ||
                        ((w_state_nxt == GO) && (r_state != GO));

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (w_tick_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_cap_res   = '0;
    w_cap_win   = '0;
    w_cap_fs    = 1'b0;
    w_cap_to    = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_state_nxt = ARM;
      ARM:  if (!start) w_state_nxt = DELAY;
      DELAY: begin
        if (w_any) begin
          w_state_nxt = FAULT;
          w_cap       = 1'b1;
          w_cap_fs    = 1'b1;
          w_cap_win   = w_first;
        end else if (w_tick && (r_delay <= DLY_W'(1))) begin
          w_state_nxt = GO;
        end
      end
      GO: begin
        // a press in the timeout cycle takes priority over the timeout
        if (w_any) begin
          w_state_nxt = DONE;
          w_cap       = 1'b1;
          w_cap_res   = r_rt;
          w_cap_win   = w_first;
        end else if (r_rt == TIME_W'(TIMEOUT_MS)) begin
          w_state_nxt = DONE;
          w_cap       = 1'b1;
          w_cap_to    = 1'b1;
          w_cap_res   = TIME_W'(TIMEOUT_MS);
        end
      end
      DONE, FAULT: if (!w_any && !start) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_delay <= '0;
      r_rt    <= '0;
    end else begin
      if (r_state == ARM && !start) begin
        r_delay <= w_delay_load;
      end else if (r_state == DELAY && w_tick && r_delay != '0) begin
        r_delay <= r_delay - DLY_W'(1);
      end
      if (r_state != GO) begin
        r_rt <= '0;
      end else if (w_tick && r_rt != '1) begin
        r_rt <= r_rt + TIME_W'(1);
      end
    end
  end

  // outputs are registered from next-state so they change on the entry edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_go          <= 1'b0;
      r_busy        <= 1'b0;
      r_capture     <= 1'b0;
      r_result      <= '0;
      r_winner      <= '0;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_go      <= (w_state_nxt == GO);
      r_busy    <= (w_state_nxt != IDLE);
      r_capture <= w_cap;
      if (w_cap) begin
        r_result      <= w_cap_res;
        r_winner      <= w_cap_win;
        r_false_start <= w_cap_fs;
        r_timeout     <= w_cap_to;
      end
    end
  end

  assign go          = r_go;
  assign capture     = r_capture;
  assign result_ms   = r_result;
  assign winner      = r_winner;
  assign false_start = r_false_start;
  assign timeout     = r_timeout;
  assign busy        = r_busy;

endmodule
